xor_parity_accum: RTL and testbench

Downstream consumer of the 2-input XOR gate stage. Takes beats of operand pairs (a, b) and forms y = a ^ b per beat. Accumulates over a frame the running parity of y, the count of y==1 beats, and the frame length. Presents one result per frame on a valid/ready output handshake. Used as the frame-level checker/aggregator behind the XOR datapath in benches and in the larger design.

---
 rtl/xor_parity_accum_if.sv | 47 ++++
 rtl/xor_parity_accum.sv | 148 ++++++++++++++
 tb/tb_xor_parity_accum.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/xor_parity_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_accum_if
// Description : Beat-in / frame-result-out handshake bundle for xor_parity_accum.
//               XOR_PARITY_CHECK_EN adds in_exp_par / out_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface xor_parity_accum_if #(
    parameter int MAX_LEN = 16
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_a;
    logic             in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CNT_W-1:0] out_ones;
    logic [CNT_W-1:0] out_len;
    logic             out_trunc;
`ifdef XOR_PARITY_CHECK_EN
    logic             in_exp_par;
    logic             out_err;
`endif

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
`ifdef XOR_PARITY_CHECK_EN
        output in_exp_par,
        input  out_err,
`endif
        input  in_ready, out_valid, out_parity, out_ones, out_len, out_trunc
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
`ifdef XOR_PARITY_CHECK_EN
        input  in_exp_par,
        output out_err,
`endif
        output in_ready, out_valid, out_parity, out_ones, out_len, out_trunc
    );
endinterface
`default_nettype wire

// File: rtl/xor_parity_accum.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_accum
// Description : Per-frame XOR parity / ones-count / length aggregator with a
//               valid/ready result port. Optional XOR_PARITY_CHECK_EN adds an
//               expected-parity compare (in_exp_par -> out_err).
// Revision    : 1.0 - initial release
// ============================================================================
module xor_parity_accum #(
    parameter int MAX_LEN = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    xor_parity_accum_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic             in_ready_q,   in_ready_d;
    logic             acc_par_q,    acc_par_d;
    logic [CNT_W-1:0] acc_ones_q,   acc_ones_d;
    logic [CNT_W-1:0] acc_len_q,    acc_len_d;
    logic             out_valid_q,  out_valid_d;
    logic             out_parity_q, out_parity_d;
    logic [CNT_W-1:0] out_ones_q,   out_ones_d;
    logic [CNT_W-1:0] out_len_q,    out_len_d;
    logic             out_trunc_q,  out_trunc_d;
`ifdef XOR_PARITY_CHECK_EN
    logic             out_err_q,    out_err_d;
`endif

    logic             y;
    logic             sum_par;
    logic [CNT_W-1:0] sum_ones;
    logic [CNT_W-1:0] sum_len;
    logic             close_frame;

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        acc_par_d    = acc_par_q;
        acc_ones_d   = acc_ones_q;
        acc_len_d    = acc_len_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_ones_d   = out_ones_q;
        out_len_d    = out_len_q;
        out_trunc_d  = out_trunc_q;
`ifdef XOR_PARITY_CHECK_EN
        out_err_d    = out_err_q;
`endif

        // First beat of a frame seeds the accumulators instead of folding in
        y           = bus.in_a ^ bus.in_b;
        sum_par     = (state_q == S_ACCUM) ? (acc_par_q ^ y) : y;
        sum_ones    = (state_q == S_ACCUM) ? (acc_ones_q + CNT_W'(y)) : CNT_W'(y);
        sum_len     = (state_q == S_ACCUM) ? (acc_len_q + ONE) : ONE;
        close_frame = bus.in_last || (sum_len == LEN_MAX);

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_par_d  = sum_par;
                    acc_ones_d = sum_ones;
                    acc_len_d  = sum_len;
                    if (close_frame) begin
                        state_d      = S_HOLD;
                        in_ready_d   = 1'b0;
                        out_valid_d  = 1'b1;
                        out_parity_d = sum_par;
                        out_ones_d   = sum_ones;
                        out_len_d    = sum_len;
                        out_trunc_d  = !bus.in_last;
`ifdef XOR_PARITY_CHECK_EN
                        out_err_d    = sum_par ^ bus.in_exp_par;
`endif
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                // Handoff returns to IDLE only; no beat is taken this cycle
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            acc_par_q    <= 1'b0;
            acc_ones_q   <= '0;
            acc_len_q    <= '0;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_ones_q   <= '0;
            out_len_q    <= '0;
            out_trunc_q  <= 1'b0;
`ifdef XOR_PARITY_CHECK_EN
            out_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            acc_par_q    <= acc_par_d;
            acc_ones_q   <= acc_ones_d;
            acc_len_q    <= acc_len_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_ones_q   <= out_ones_d;
            out_len_q    <= out_len_d;
            out_trunc_q  <= out_trunc_d;
`ifdef XOR_PARITY_CHECK_EN
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_ones   = out_ones_q;
    assign bus.out_len    = out_len_q;
    assign bus.out_trunc  = out_trunc_q;
`ifdef XOR_PARITY_CHECK_EN
    assign bus.out_err    = out_err_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_xor_parity_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_parity_accum
// Description : Directed self-checking bench for xor_parity_accum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_parity_accum;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    xor_parity_accum_if #(.MAX_LEN(MAX_LEN)) bus ();

    xor_parity_accum #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, out_parity, out_ones, out_len, out_trunc}
    function automatic logic [2*CNT_W+2:0] res_vec();
        return {bus.out_valid, bus.out_parity, bus.out_ones, bus.out_len, bus.out_trunc};
    endfunction

    function automatic logic [2*CNT_W+2:0] exp_vec(input logic v, input logic p,
                                                   input int ones, input int len,
                                                   input logic t);
        return {v, p, CNT_W'(ones), CNT_W'(len), t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic a, input logic b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 1'bx;
        bus.in_b     = 1'bx;
        bus.in_last  = 1'b0;
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (res_vec() !== exp_vec(0, 0, 0, 0, 0))
            $display("FAIL reset_outputs: got %h want %h", res_vec(), exp_vec(0, 0, 0, 0, 0));
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        bus.out_ready = 1'b1;
        beat(0, 0, 0);
        beat(0, 1, 0);
        beat(1, 0, 0);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_no_early_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        beat(1, 1, 1);
        n_checks++;
        if (res_vec() !== exp_vec(1, 0, 2, 4, 0))
            $display("FAIL basic_result: got %h want %h", res_vec(), exp_vec(1, 0, 2, 4, 0));
        else n_pass++;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL basic_handoff: got valid,ready=%b want 01", {bus.out_valid, bus.in_ready});
        else n_pass++;
    endtask

    task automatic test_trunc();
        for (int i = 0; i < MAX_LEN; i++) beat(1, 0, 0);
        n_checks++;
        if (res_vec() !== exp_vec(1, 0, 16, 16, 1))
            $display("FAIL trunc_result: got %h want %h", res_vec(), exp_vec(1, 0, 16, 16, 1));
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL trunc_in_ready: got %b want 0", bus.in_ready);
        else n_pass++;
        beat(0, 1, 1);  // beat 17 must be refused
        n_checks++;
        if (res_vec() !== exp_vec(1, 0, 16, 16, 1))
            $display("FAIL trunc_beat17_ignored: got %h want %h", res_vec(), exp_vec(1, 0, 16, 16, 1));
        else n_pass++;
        handoff();
    endtask

    task automatic test_hold();
        beat(1, 0, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = 1'b0;
        bus.in_b     = 1'b1;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({res_vec(), bus.in_ready} !== {exp_vec(1, 1, 1, 1, 0), 1'b0})
                $display("FAIL hold_cycle%0d: got %h want %h", i, {res_vec(), bus.in_ready},
                         {exp_vec(1, 1, 1, 1, 0), 1'b0});
            else n_pass++;
            tick();
        end
        handoff();  // in_valid still high: must not be taken during handoff
        bus.in_valid = 1'b0;
        n_checks++;
        if ({res_vec(), bus.in_ready} !== {exp_vec(0, 1, 1, 1, 0), 1'b1})
            $display("FAIL hold_handoff: got %h want %h", {res_vec(), bus.in_ready},
                     {exp_vec(0, 1, 1, 1, 0), 1'b1});
        else n_pass++;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL hold_no_bypass: got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_gaps();
        beat(1, 0, 0);
        tick(); tick();
        beat(0, 1, 0);
        tick(); tick();
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL gaps_mid: got valid,ready=%b want 01", {bus.out_valid, bus.in_ready});
        else n_pass++;
        beat(1, 0, 1);
        n_checks++;
        if (res_vec() !== exp_vec(1, 1, 3, 3, 0))
            $display("FAIL gaps_result: got %h want %h", res_vec(), exp_vec(1, 1, 3, 3, 0));
        else n_pass++;
        handoff();
    endtask

    task automatic test_mid_reset();
        beat(1, 1, 0);
        beat(0, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({res_vec(), bus.in_ready} !== {exp_vec(0, 0, 0, 0, 0), 1'b1})
            $display("FAIL midrst_state: got %h want %h", {res_vec(), bus.in_ready},
                     {exp_vec(0, 0, 0, 0, 0), 1'b1});
        else n_pass++;
        beat(0, 1, 0);
        beat(1, 1, 1);
        n_checks++;
        if (res_vec() !== exp_vec(1, 1, 1, 2, 0))
            $display("FAIL midrst_result: got %h want %h", res_vec(), exp_vec(1, 1, 1, 2, 0));
        else n_pass++;
        handoff();
    endtask

    task automatic test_last_at_max();
        for (int i = 0; i < MAX_LEN - 1; i++) beat(0, 1, 0);
        beat(0, 0, 1);
        n_checks++;
        if (res_vec() !== exp_vec(1, 1, 15, 16, 0))
            $display("FAIL last_at_max: got %h want %h", res_vec(), exp_vec(1, 1, 15, 16, 0));
        else n_pass++;
        handoff();
    endtask

`ifdef XOR_PARITY_CHECK_EN
    task automatic test_check();
        bus.in_exp_par = 1'b1;
        beat(1, 0, 0);
        beat(0, 1, 0);
        beat(1, 1, 1);
        n_checks++;
        if ({bus.out_parity, bus.out_err} !== 2'b01)
            $display("FAIL check_err_set: got par,err=%b want 01", {bus.out_parity, bus.out_err});
        else n_pass++;
        handoff();
        bus.in_exp_par = 1'b0;
        beat(1, 0, 0);
        beat(0, 1, 0);
        beat(1, 1, 1);
        n_checks++;
        if ({bus.out_parity, bus.out_err} !== 2'b00)
            $display("FAIL check_err_clear: got par,err=%b want 00", {bus.out_parity, bus.out_err});
        else n_pass++;
        handoff();
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 1'b0;
        bus.in_b      = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef XOR_PARITY_CHECK_EN
        bus.in_exp_par = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_basic_frame();
        test_trunc();
        test_hold();
        test_gaps();
        test_mid_reset();
        test_last_at_max();
`ifdef XOR_PARITY_CHECK_EN
        test_check();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
